// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller for a pipelined MIPS-style core.
// It holds architectural HI/LO, accepts mult/multu/div/divu/mthi/mtlo from EX,
// keeps busy high for a fixed latency and commits the whole result at the end.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] Rs_IN,
  input  logic [31:0] Rt_IN,
  input  logic        cancel,
  input  logic        md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi_OUT,
  output logic [31:0] lo_OUT
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rs_q, rs_d, rt_q, rt_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  logic          accept;
  logic          signedOp, negA, negB, resValid;
  logic [63:0]   mulA, mulB, product;
  logic [31:0]   absA, absB, quo, rem, qFix, rFix, resHi, resLo;

  assign busy      = (state_q == S_BUSY);
  assign hi_OUT    = hi_q;
  assign lo_OUT    = lo_q;
  assign accept    = start & ~cancel & ~busy & (md_op <= 3'd5);
  assign stall_req = md_use & (busy | (start & ~cancel & (md_op <= 3'd3)));

  // Result of the captured operation; division goes through magnitudes so the
  // most-negative / -1 case falls out as 0x80000000 rem 0 with no special case.
  always_comb begin
    signedOp = ~op_q[0];
    mulA     = {{32{signedOp & rs_q[31]}}, rs_q};
    mulB     = {{32{signedOp & rt_q[31]}}, rt_q};
    product  = mulA * mulB;
    negA     = signedOp & rs_q[31];
    negB     = signedOp & rt_q[31];
    absA     = negA ? (32'd0 - rs_q) : rs_q;
    absB     = negB ? (32'd0 - rt_q) : rt_q;
    quo      = 32'd0;
    rem      = 32'd0;
    if (absB != 32'd0) begin
      quo = absA / absB;
      rem = absA % absB;
    end
    qFix     = (negA ^ negB) ? (32'd0 - quo) : quo;
    rFix     = negA ? (32'd0 - rem) : rem;
    resValid = 1'b1;
    resHi    = product[63:32];
    resLo    = product[31:0];
    if (op_q[1]) begin
      resValid = (absB != 32'd0);
      resHi    = rFix;
      resLo    = qFix;
    end
  end

  // Next-state logic: accept in idle, count down while busy, commit on last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (md_op)
            3'd4:    hi_d = Rs_IN;
            3'd5:    lo_d = Rs_IN;
            default: begin
              rs_d    = Rs_IN;
              rt_d    = Rt_IN;
              op_d    = md_op[1:0];
              cnt_d   = md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              state_d = S_BUSY;
            end
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          if (resValid) begin
            hi_d = resHi;
            lo_d = resLo;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed scenarios plus random traffic against a cycle-level
// behavioural model of HI/LO, the busy window and stall_req.
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk, reset, start, cancel, md_use;
  logic [2:0]  md_op;
  logic [31:0] Rs_IN, Rt_IN;
  logic        busy, stall_req;
  logic [31:0] hi_OUT, lo_OUT;

  int checks   = 0;
  int failures = 0;

  // Model state: architectural HI/LO, cycles left in flight, pending result.
  logic [31:0] mHi, mLo, pHi, pLo;
  logic        pValid;
  int          mLeft;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .Rs_IN(Rs_IN), .Rt_IN(Rt_IN), .cancel(cancel), .md_use(md_use),
    .busy(busy), .stall_req(stall_req), .hi_OUT(hi_OUT), .lo_OUT(lo_OUT)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mHi = 0; mLo = 0; pHi = 0; pLo = 0; pValid = 0; mLeft = 0;
  endtask

  // Architectural effect of one rising edge, from the instruction semantics.
  task automatic modelEdge();
    longint a, b, q, r;
    logic [63:0] p;
    if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0 && pValid) begin
        mHi = pHi;
        mLo = pLo;
      end
    end else if (start && !cancel && md_op <= 3'd5) begin
      if (md_op == 3'd4) mHi = Rs_IN;
      else if (md_op == 3'd5) mLo = Rs_IN;
      else begin
        pValid = 1'b1;
        if (md_op <= 3'd1) begin
          if (md_op == 3'd0) p = 64'(longint'($signed(Rs_IN)) * longint'($signed(Rt_IN)));
          else               p = {32'd0, Rs_IN} * {32'd0, Rt_IN};
          pHi = p[63:32];
          pLo = p[31:0];
          mLeft = MULT_N;
        end else begin
          if (md_op == 3'd2) begin
            a = longint'($signed(Rs_IN));
            b = longint'($signed(Rt_IN));
          end else begin
            a = longint'({32'd0, Rs_IN});
            b = longint'({32'd0, Rt_IN});
          end
          if (b == 0) pValid = 1'b0;
          else begin
            q = a / b;
            r = a % b;
            pLo = q[31:0];
            pHi = r[31:0];
          end
          mLeft = DIV_N;
        end
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, check stall combinationally,
  // then check registered outputs just after the rising edge.
  task automatic applyStimulus(input logic s, input logic [2:0] op, input logic [31:0] rs,
                               input logic [31:0] rt, input logic c, input logic u);
    logic expStall;
    @(negedge clk);
    start = s; md_op = op; Rs_IN = rs; Rt_IN = rt; cancel = c; md_use = u;
    #1;
    expStall = u & ((mLeft > 0) | (s & ~c & (op <= 3'd3)));
    checkOutput("stall_req", {31'd0, stall_req}, {31'd0, expStall});
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("busy", {31'd0, busy}, {31'd0, logic'(mLeft > 0)});
    checkOutput("hi", hi_OUT, mHi);
    checkOutput("lo", lo_OUT, mLo);
  endtask

  task automatic idle(input logic u);
    applyStimulus(1'b0, 3'd7, 32'd0, 32'd0, 1'b0, u);
  endtask

  // Issue an operation then idle until busy drops, counting busy cycles (bounded).
  task automatic runOp(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic u, output int n);
    n = 0;
    applyStimulus(1'b1, op, rs, rt, 1'b0, u);
    if (busy) n++;
    for (int i = 0; i < 40 && busy; i++) begin
      idle(u);
      if (busy) n++;
    end
    checkOutput("op_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    logic [2:0] op;
    logic [31:0] rs, rt;
    start = 0; md_op = 0; Rs_IN = 0; Rt_IN = 0; cancel = 0; md_use = 0;
    modelReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_hi", hi_OUT, 32'd0);
    checkOutput("rst_lo", lo_OUT, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // mult / multu of 0xFFFFFFFE and 3, stall observed with md_use high
    runOp(3'd0, 32'hFFFFFFFE, 32'd3, 1'b1, n);
    checkOutput("mult_busy_len", n, 32'd5);
    checkOutput("mult_hi", hi_OUT, 32'hFFFFFFFF);
    checkOutput("mult_lo", lo_OUT, 32'hFFFFFFFA);
    checkOutput("stall_after", {31'd0, stall_req}, 32'd0);
    runOp(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, n);
    checkOutput("multu_hi", hi_OUT, 32'h00000002);
    checkOutput("multu_lo", lo_OUT, 32'hFFFFFFFA);

    // signed div -7/2, then divu by zero leaves HI/LO alone
    runOp(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, n);
    checkOutput("div_busy_len", n, 32'd10);
    checkOutput("div_lo", lo_OUT, 32'hFFFFFFFD);
    checkOutput("div_hi", hi_OUT, 32'hFFFFFFFF);
    applyStimulus(1'b1, 3'd4, 32'h11, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd5, 32'h22, 32'd0, 1'b0, 1'b0);
    runOp(3'd3, 32'd7, 32'd0, 1'b0, n);
    checkOutput("div0_hi", hi_OUT, 32'h11);
    checkOutput("div0_lo", lo_OUT, 32'h22);

    // overflow case of signed division
    runOp(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, n);
    checkOutput("ovf_lo", lo_OUT, 32'h80000000);
    checkOutput("ovf_hi", hi_OUT, 32'h0);

    // mthi, then a cancelled mthi
    applyStimulus(1'b1, 3'd4, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1);
    checkOutput("mthi_hi", hi_OUT, 32'hDEADBEEF);
    checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
    applyStimulus(1'b1, 3'd4, 32'h12345678, 32'd0, 1'b1, 1'b0);
    checkOutput("mthi_cancel", hi_OUT, 32'hDEADBEEF);

    // second start two cycles into a mult is ignored
    applyStimulus(1'b1, 3'd0, 32'd2, 32'd3, 1'b0, 1'b0);
    n = 1;
    idle(1'b0);
    n++;
    applyStimulus(1'b1, 3'd0, 32'h10, 32'h10, 1'b0, 1'b0);
    if (busy) n++;
    for (int i = 0; i < 40 && busy; i++) begin
      idle(1'b0);
      if (busy) n++;
    end
    checkOutput("sb_busy_len", n, 32'd5);
    checkOutput("sb_hi", hi_OUT, 32'd0);
    checkOutput("sb_lo", lo_OUT, 32'd6);

    // reset during cycle 4 of a div: cleared at once, nothing committed later
    applyStimulus(1'b1, 3'd4, 32'hAAAA5555, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd2, 32'd100, 32'd7, 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstmid_hi", hi_OUT, 32'd0);
    checkOutput("rstmid_lo", lo_OUT, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) idle(1'b0);
    checkOutput("rstmid_nocommit", lo_OUT, 32'd0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       rs = 32'h80000000;
        1:       rs = 32'($urandom_range(0, 20));
        default: rs = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rt = 32'd0;
        1:       rt = 32'hFFFFFFFF;
        2:       rt = 32'($urandom_range(1, 20));
        default: rt = $urandom;
      endcase
      applyStimulus(logic'($urandom_range(0, 2) != 0), op, rs, rt,
                    logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
